xdma: RTL and testbench
=======================

Name: xdma

Overview:
- Block-transfer DMA engine that drives the DMA-side data port of the shared program/data RAM (`dma_sel`, `dma_we`, `dma_addr`, `dma_data_in`, `dma_data_out`).
- Moves word blocks between that RAM and an external single-outstanding req/ack memory bus, in either direction.
- Configured and polled by the controller through a small register port.
- The RAM gives the controller priority. The DMA only proceeds when `dma_grant` (= `~data_sel`) is high.

Parameters:
- ADDR_W, `ADDR_W (xdefs): controller address width; the RAM word address is ADDR_W-1 bits.
- DATA_W, `DATA_W (xdefs): data word width.
- EXT_ADDR_W, 32: external bus word-address width.
- LEN_W, 16: transfer length counter width, in words.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- cfg_sel  in  1  config register access strobe.
- cfg_we  in  1  config write enable.
- cfg_addr  in  2  register select: 0 EXT_ADDR, 1 INT_ADDR, 2 LEN, 3 CTRL.
- cfg_data_in  in  DATA_W  config write data.
- cfg_data_out  out  DATA_W  config read data, combinational from cfg_addr.
- dma_grant  in  1  RAM DMA port available this cycle.
- dma_sel  out  1  RAM DMA port enable.
- dma_we  out  1  RAM DMA write enable.
- dma_addr  out  ADDR_W-1  RAM word address.
- dma_data_in  out  DATA_W  write data to RAM.
- dma_data_out  in  DATA_W  RAM read data, valid the cycle after a granted read.
- ext_req  out  1  external request, held until ext_ack.
- ext_we  out  1  external write.
- ext_addr  out  EXT_ADDR_W  external word address.
- ext_wdata  out  DATA_W  external write data.
- ext_ack  in  1  completes the request; ext_rdata valid in the same cycle for reads.
- ext_rdata  in  DATA_W  external read data.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - All registers cleared to 0.
  - Outputs dma_sel, dma_we, ext_req, ext_we, busy, done = 0.
  - dma_addr, ext_addr, dma_data_in, ext_wdata = 0.
  - Reset mid-transfer aborts immediately; no further RAM or bus access occurs.
- Config writes (cfg_sel & cfg_we, posedge):
  - Registers 0, 1 and 2 are ignored while busy.
  - CTRL write: bit1 = DIR (0: ext->RAM, 1: RAM->ext); bit0 = START.
  - START is accepted only when idle. It loads the working counters ea<=EXT_ADDR, ia<=INT_ADDR, cnt<=LEN.
- Config reads: CTRL reads {.., DONE_STICKY bit2, DIR bit1, busy bit0}.
  - DONE_STICKY is set on completion and cleared by any START.
- Zero length: START with LEN=0 goes IDLE -> FIN directly. done pulses the next cycle; no RAM or bus access occurs.
- FSM states: IDLE, EXT_RD, RAM_WR, RAM_RD, RAM_WAIT, EXT_WR, FIN.
- DIR=0 (ext->RAM):
  - EXT_RD: ext_req=1, ext_we=0, ext_addr=ea. On ext_ack, latch ext_rdata into buf and go to RAM_WR.
  - RAM_WR: dma_sel=1, dma_we=1, dma_addr=ia, dma_data_in=buf. If dma_grant, the write takes effect, then ia++, ea++, cnt--. Next state is FIN if cnt==1, else EXT_RD. Without grant, stay and hold.
- DIR=1 (RAM->ext):
  - RAM_RD: dma_sel=1, dma_we=0, dma_addr=ia. If dma_grant, go to RAM_WAIT.
  - RAM_WAIT: latch dma_data_out into buf, go to EXT_WR.
  - EXT_WR: ext_req=1, ext_we=1, ext_addr=ea, ext_wdata=buf. On ext_ack, ia++, ea++, cnt--. Next state is FIN if cnt==1, else RAM_RD.
- FIN: done=1 for one cycle, set DONE_STICKY, return to IDLE.
- busy = (state != IDLE).
- ext_req, ext_addr, ext_we and ext_wdata are held stable from assertion until the ack cycle. ext_req drops the cycle after ack.
- dma_sel is asserted only in RAM_WR and RAM_RD. It stays asserted while ungranted (the RAM mux ignores it).
- ia wraps modulo 2^(ADDR_W-1); ea wraps modulo 2^EXT_ADDR_W. There is no error on wrap.
- Minimum throughput per word, with no wait states:
  - DIR=0: 2 cycles (EXT_RD with immediate ack, then RAM_WR).
  - DIR=1: 3 cycles (RAM_RD, RAM_WAIT, EXT_WR).

Test Plan:
- Reset values: hold rst=0 while toggling inputs. All outputs must read 0 and cfg_data_out for CTRL must read 0. Release reset; no ext_req or dma_sel may appear.
- ext->RAM, LEN=4, EXT_ADDR=0x100, INT_ADDR=0x10, ext_ack one cycle after each req with rdata=0xA0..0xA3, dma_grant=1:
  - RAM words 0x10..0x13 = 0xA0..0xA3.
  - ext_addr sequence 0x100..0x103.
  - Exactly one done pulse; busy low after it.
- RAM->ext, LEN=3, INT_ADDR=0x20, RAM preloaded 0x55,0x66,0x77:
  - ext writes to EXT_ADDR..+2 carry 0x55,0x66,0x77.
  - ext_wdata stays stable while ack is delayed 3 cycles.
- Arbitration: dma_grant=0 for 5 cycles during RAM_WR, then 1.
  - dma_addr and dma_data_in hold for those cycles.
  - The write lands exactly once and the count is unaffected.
- Boundaries:
  - LEN=0 START: done pulses with no ext_req and no dma_sel.
  - INT_ADDR=max with LEN=2: the second word goes to RAM address 0.
  - A config write to LEN while busy leaves the register read-back unchanged.
- Mid-transfer reset: assert rst low during EXT_WR with ext_req=1. ext_req drops immediately (asynchronous); after release, state is IDLE and DONE_STICKY=0.

Source files
------------

// File: rtl/xdma.sv
`default_nettype none
// ============================================================================
// Module   : xdma
// Brief    : Block-transfer DMA between the shared RAM DMA port and an
//            external single-outstanding req/ack word bus.
// Revision : 1.0 - initial release
// ============================================================================
module xdma #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int EXT_ADDR_W = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_sel,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data_in,
  output logic [DATA_W-1:0]     cfg_data_out,
  input  logic                  dma_grant,
  output logic                  dma_sel,
  output logic                  dma_we,
  output logic [ADDR_W-2:0]     dma_addr,
  output logic [DATA_W-1:0]     dma_data_in,
  input  logic [DATA_W-1:0]     dma_data_out,
  output logic                  ext_req,
  output logic                  ext_we,
  output logic [EXT_ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0]     ext_wdata,
  input  logic                  ext_ack,
  input  logic [DATA_W-1:0]     ext_rdata,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] c_REG_EXT  = 2'd0;
  localparam logic [1:0] c_REG_INT  = 2'd1;
  localparam logic [1:0] c_REG_LEN  = 2'd2;
  localparam logic [1:0] c_REG_CTRL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXT_RD   = 3'd1,
    S_RAM_WR   = 3'd2,
    S_RAM_RD   = 3'd3,
    S_RAM_WAIT = 3'd4,
    S_EXT_WR   = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [EXT_ADDR_W-1:0]   r_ext_addr_cfg;
  logic [ADDR_W-2:0]       r_int_addr_cfg;
  logic [LEN_W-1:0]        r_len_cfg;
  logic                    r_dir;
  logic                    r_done_sticky;
  logic [EXT_ADDR_W-1:0]   r_ea;
  logic [ADDR_W-2:0]       r_ia;
  logic [LEN_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_buf;

  logic w_idle;
  logic w_busy;
  logic w_cfg_wr;
  logic w_start;
  logic w_last;
  logic w_step;

  assign w_idle   = (r_state == S_IDLE);
  assign w_busy   = ~w_idle;
  assign w_cfg_wr = cfg_sel & cfg_we & w_idle;
  assign w_start  = w_cfg_wr & (cfg_addr == c_REG_CTRL) & cfg_data_in[0];
  assign w_last   = (r_cnt == LEN_W'(1));

  assign busy        = w_busy;
  assign done        = (r_state == S_FIN);
  assign dma_addr    = r_ia;
  assign dma_data_in = r_buf;
  assign ext_addr    = r_ea;
  assign ext_wdata   = r_buf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    dma_sel      = 1'b0;
    dma_we       = 1'b0;
    ext_req      = 1'b0;
    ext_we       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (r_len_cfg == '0)      w_next_state = S_FIN;
          else if (cfg_data_in[1])  w_next_state = S_RAM_RD;
          else                      w_next_state = S_EXT_RD;
        end
      end
      S_EXT_RD: begin
        ext_req = 1'b1;
        if (ext_ack) w_next_state = S_RAM_WR;
      end
      S_RAM_WR: begin
        dma_sel = 1'b1;
        dma_we  = 1'b1;
        if (dma_grant) begin
          w_step       = 1'b1;
          w_next_state = w_last ? S_FIN : S_EXT_RD;
        end
      end
      S_RAM_RD: begin
        dma_sel = 1'b1;
        if (dma_grant) w_next_state = S_RAM_WAIT;
      end
      S_RAM_WAIT: w_next_state = S_EXT_WR;
      S_EXT_WR: begin
        ext_req = 1'b1;
        ext_we  = 1'b1;
        if (ext_ack) begin
          w_step       = 1'b1;
          w_next_state = w_last ? S_FIN : S_RAM_RD;
        end
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Config registers, working counters and the single-word transfer buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext_addr_cfg <= '0;
      r_int_addr_cfg <= '0;
      r_len_cfg      <= '0;
      r_dir          <= 1'b0;
      r_done_sticky  <= 1'b0;
      r_ea           <= '0;
      r_ia           <= '0;
      r_cnt          <= '0;
      r_buf          <= '0;
    end else begin
      if (w_cfg_wr) begin
        case (cfg_addr)
          c_REG_EXT:  r_ext_addr_cfg <= EXT_ADDR_W'(cfg_data_in);
          c_REG_INT:  r_int_addr_cfg <= (ADDR_W-1)'(cfg_data_in);
          c_REG_LEN:  r_len_cfg      <= LEN_W'(cfg_data_in);
          default:    r_dir          <= cfg_data_in[1];
        endcase
      end
      if (w_start) begin
        r_ea          <= r_ext_addr_cfg;
        r_ia          <= r_int_addr_cfg;
        r_cnt         <= r_len_cfg;
        r_done_sticky <= 1'b0;
      end
      if (r_state == S_FIN) r_done_sticky <= 1'b1;
      if ((r_state == S_EXT_RD) && ext_ack) r_buf <= ext_rdata;
      if (r_state == S_RAM_WAIT) r_buf <= dma_data_out;
      // Both address counters wrap silently at their natural widths.
      if (w_step) begin
        r_ia  <= r_ia + (ADDR_W-1)'(1);
        r_ea  <= r_ea + EXT_ADDR_W'(1);
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  always_comb begin
    cfg_data_out = '0;
    case (cfg_addr)
      c_REG_EXT:  cfg_data_out = DATA_W'(r_ext_addr_cfg);
      c_REG_INT:  cfg_data_out = DATA_W'(r_int_addr_cfg);
      c_REG_LEN:  cfg_data_out = DATA_W'(r_len_cfg);
      default:    cfg_data_out = DATA_W'({r_done_sticky, r_dir, w_busy});
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_xdma.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_xdma
// Brief    : Scoreboard bench for xdma with RAM and external-bus responders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xdma;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 32;
  localparam int EXT_ADDR_W = 32;
  localparam int LEN_W      = 16;
  localparam int RAM_AW     = ADDR_W - 1;

  logic                  clk;
  logic                  rst;
  logic                  cfg_sel;
  logic                  cfg_we;
  logic [1:0]            cfg_addr;
  logic [DATA_W-1:0]     cfg_data_in;
  logic [DATA_W-1:0]     cfg_data_out;
  logic                  dma_grant;
  logic                  dma_sel;
  logic                  dma_we;
  logic [RAM_AW-1:0]     dma_addr;
  logic [DATA_W-1:0]     dma_data_in;
  logic [DATA_W-1:0]     dma_data_out;
  logic                  ext_req;
  logic                  ext_we;
  logic [EXT_ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic                  ext_ack;
  logic [DATA_W-1:0]     ext_rdata;
  logic                  busy;
  logic                  done;

  xdma #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .EXT_ADDR_W(EXT_ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_sel(cfg_sel), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data_in(cfg_data_in), .cfg_data_out(cfg_data_out),
    .dma_grant(dma_grant), .dma_sel(dma_sel), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_data_in(dma_data_in), .dma_data_out(dma_data_out),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [EXT_ADDR_W-1:0] addr;
    logic                  we;
    logic [DATA_W-1:0]     data;
  } ext_t;

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_t;

  ext_t exp_ext[$];
  ram_t exp_ram[$];
  int   exp_done;
  bit   forbid;
  int   n_chk;
  int   n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // RAM model: granted write lands at the edge, granted read data appears after it.
  logic [DATA_W-1:0] ram [0:(1<<RAM_AW)-1];
  logic              pl_en;
  logic [RAM_AW-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (dma_sel && dma_grant) begin
      if (dma_we) ram[dma_addr] <= dma_data_in;
      else        dma_data_out <= ram[dma_addr];
    end
  end

  // External bus responder: acks after ack_delay extra cycles of request.
  logic [DATA_W-1:0] ext_mem [logic [EXT_ADDR_W-1:0]];
  int ack_delay;
  int wait_cnt;

  initial begin
    ext_ack   = 1'b0;
    ext_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk); #1;
      if (ext_ack) begin
        ext_ack = 1'b0;
      end else if (!ext_req) begin
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        ext_ack   = 1'b1;
        ext_rdata = ext_mem.exists(ext_addr) ? ext_mem[ext_addr] : '0;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a RAM write, a bus
  // transaction or a done pulse; also checks bus signal stability.
  logic                  prev_pend;
  logic [EXT_ADDR_W-1:0] prev_addr;
  logic                  prev_we;
  logic [DATA_W-1:0]     prev_wdata;

  initial begin
    ram_t er;
    ext_t ee;
    prev_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (dma_sel && dma_we && dma_grant) begin
        chk("ram_wr_expected", 64'(exp_ram.size() > 0), 64'(1));
        if (exp_ram.size() > 0) begin
          er = exp_ram.pop_front();
          chk("ram_wr_addr", 64'(dma_addr), 64'(er.addr));
          chk("ram_wr_data", 64'(dma_data_in), 64'(er.data));
        end
      end
      if (ext_req && ext_ack) begin
        chk("ext_txn_expected", 64'(exp_ext.size() > 0), 64'(1));
        if (exp_ext.size() > 0) begin
          ee = exp_ext.pop_front();
          chk("ext_addr", 64'(ext_addr), 64'(ee.addr));
          chk("ext_we", 64'(ext_we), 64'(ee.we));
          if (ee.we) chk("ext_wdata", 64'(ext_wdata), 64'(ee.data));
        end
      end
      if (ext_req && prev_pend) begin
        chk("ext_addr_stable", 64'(ext_addr), 64'(prev_addr));
        chk("ext_we_stable", 64'(ext_we), 64'(prev_we));
        chk("ext_wdata_stable", 64'(ext_wdata), 64'(prev_wdata));
      end
      prev_pend  = ext_req && !ext_ack;
      prev_addr  = ext_addr;
      prev_we    = ext_we;
      prev_wdata = ext_wdata;
      if (done) begin
        chk("done_expected", 64'(exp_done > 0), 64'(1));
        if (exp_done > 0) exp_done--;
      end
      if (forbid) chk("no_access", 64'({ext_req, dma_sel}), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    cfg_sel = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_data_in = d;
    @(posedge clk); #1;
    cfg_sel = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [DATA_W-1:0] d);
    cfg_addr = a;
    #1;
    d = cfg_data_out;
  endtask

  task automatic ram_load(input logic [RAM_AW-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic push_ext(input logic [EXT_ADDR_W-1:0] a, input logic w, input logic [DATA_W-1:0] d);
    ext_t e;
    e.addr = a; e.we = w; e.data = d;
    exp_ext.push_back(e);
  endtask

  task automatic push_ram(input logic [RAM_AW-1:0] a, input logic [DATA_W-1:0] d);
    ram_t e;
    e.addr = a; e.data = d;
    exp_ram.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #2;
      if (!busy && exp_done == 0 && exp_ram.size() == 0 && exp_ext.size() == 0) ok = 1'b1;
    end
    chk({name, "_complete"}, 64'(ok), 64'(1));
  endtask

  logic [DATA_W-1:0] rd;
  bit                found;

  initial begin
    rst = 1'b0; cfg_sel = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data_in = '0;
    dma_grant = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    ack_delay = 0; forbid = 1'b0; exp_done = 0; n_chk = 0; n_fail = 0;

    // Reset held while inputs wiggle: everything must stay at zero.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      cfg_sel     = 1'($urandom_range(0, 1));
      cfg_we      = 1'($urandom_range(0, 1));
      cfg_addr    = 2'($urandom_range(0, 3));
      cfg_data_in = $urandom;
      dma_grant   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_out_ctrl", 64'({dma_sel, dma_we, ext_req, ext_we, busy, done}), 64'(0));
      chk("rst_addrs", 64'({dma_addr, ext_addr}), 64'(0));
      chk("rst_data", 64'({dma_data_in, ext_wdata}), 64'(0));
      chk("rst_cfg_rd", 64'(cfg_data_out), 64'(0));
    end
    cfg_sel = 1'b0; cfg_we = 1'b0;
    cfg_read(2'd3, rd);
    chk("rst_ctrl_rd", 64'(rd), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1; forbid = 1'b1;
    repeat (5) @(posedge clk);
    #1 forbid = 1'b0;

    // ext -> RAM, four words, ack one cycle after request.
    dma_grant = 1'b1; ack_delay = 1;
    for (int k = 0; k < 4; k++) begin
      ext_mem[EXT_ADDR_W'(32'h100 + k)] = DATA_W'(32'hA0 + k);
      push_ext(EXT_ADDR_W'(32'h100 + k), 1'b0, '0);
      push_ram(RAM_AW'(32'h10 + k), DATA_W'(32'hA0 + k));
    end
    cfg_write(2'd0, 32'h100);
    cfg_write(2'd1, 32'h10);
    cfg_write(2'd2, 32'd4);
    exp_done = 1;
    cfg_write(2'd3, 32'h1);
    wait_idle("e2r");
    for (int k = 0; k < 4; k++) chk("e2r_ram", 64'(ram[RAM_AW'(32'h10 + k)]), 64'(32'hA0 + k));
    chk("e2r_busy_low", 64'(busy), 64'(0));
    cfg_read(2'd3, rd);
    chk("e2r_ctrl_rd", 64'(rd), 64'(4));

    // RAM -> ext, three words, ack delayed three cycles.
    ram_load(RAM_AW'(32'h20), 32'h55);
    ram_load(RAM_AW'(32'h21), 32'h66);
    ram_load(RAM_AW'(32'h22), 32'h77);
    ack_delay = 3;
    push_ext(32'h300, 1'b1, 32'h55);
    push_ext(32'h301, 1'b1, 32'h66);
    push_ext(32'h302, 1'b1, 32'h77);
    cfg_write(2'd0, 32'h300);
    cfg_write(2'd1, 32'h20);
    cfg_write(2'd2, 32'd3);
    exp_done = 1;
    cfg_write(2'd3, 32'h3);
    wait_idle("r2e");
    cfg_read(2'd3, rd);
    chk("r2e_ctrl_rd", 64'(rd), 64'(6));

    // Arbitration: grant withheld for five RAM_WR cycles.
    dma_grant = 1'b0; ack_delay = 0;
    ext_mem[32'h400] = 32'h11;
    ext_mem[32'h401] = 32'h22;
    push_ext(32'h400, 1'b0, '0);
    push_ext(32'h401, 1'b0, '0);
    push_ram(RAM_AW'(32'h40), 32'h11);
    push_ram(RAM_AW'(32'h41), 32'h22);
    cfg_write(2'd0, 32'h400);
    cfg_write(2'd1, 32'h40);
    cfg_write(2'd2, 32'd2);
    exp_done = 1;
    cfg_write(2'd3, 32'h1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (dma_sel && dma_we) found = 1'b1;
    end
    chk("arb_reach_ram_wr", 64'(found), 64'(1));
    if (found) begin
      chk("arb_addr", 64'(dma_addr), 64'(32'h40));
      chk("arb_data", 64'(dma_data_in), 64'(32'h11));
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("arb_sel_held", 64'({dma_sel, dma_we}), 64'(3));
        chk("arb_addr_held", 64'(dma_addr), 64'(32'h40));
        chk("arb_data_held", 64'(dma_data_in), 64'(32'h11));
      end
    end
    @(posedge clk); #1;
    dma_grant = 1'b1;
    wait_idle("arb");
    chk("arb_ram0", 64'(ram[RAM_AW'(32'h40)]), 64'(32'h11));
    chk("arb_ram1", 64'(ram[RAM_AW'(32'h41)]), 64'(32'h22));

    // Zero length: done only, no accesses.
    cfg_write(2'd2, 32'd0);
    forbid = 1'b1;
    exp_done = 1;
    cfg_write(2'd3, 32'h1);
    wait_idle("len0");
    repeat (2) @(posedge clk);
    #1 forbid = 1'b0;
    cfg_read(2'd3, rd);
    chk("len0_ctrl_rd", 64'(rd), 64'(4));

    // INT_ADDR at its maximum wraps to 0; config writes while busy are ignored.
    ack_delay = 4;
    ext_mem[32'h500] = 32'hB0;
    ext_mem[32'h501] = 32'hB1;
    push_ext(32'h500, 1'b0, '0);
    push_ext(32'h501, 1'b0, '0);
    push_ram(RAM_AW'((1 << RAM_AW) - 1), 32'hB0);
    push_ram(RAM_AW'(0), 32'hB1);
    cfg_write(2'd0, 32'h500);
    cfg_write(2'd1, 32'((1 << RAM_AW) - 1));
    cfg_write(2'd2, 32'd2);
    exp_done = 1;
    cfg_write(2'd3, 32'h1);
    cfg_write(2'd2, 32'd9);
    cfg_write(2'd0, 32'h999);
    cfg_read(2'd2, rd);
    chk("busy_len_rd", 64'(rd), 64'(2));
    cfg_read(2'd0, rd);
    chk("busy_ext_rd", 64'(rd), 64'(32'h500));
    cfg_read(2'd3, rd);
    chk("busy_ctrl_rd", 64'(rd), 64'(1));
    wait_idle("wrap");
    chk("wrap_ram_max", 64'(ram[RAM_AW'((1 << RAM_AW) - 1)]), 64'(32'hB0));
    chk("wrap_ram_0", 64'(ram[RAM_AW'(0)]), 64'(32'hB1));

    // Reset asserted while an external write is waiting for ack.
    ack_delay = 50;
    cfg_write(2'd0, 32'h600);
    cfg_write(2'd1, 32'h20);
    cfg_write(2'd2, 32'd2);
    cfg_write(2'd3, 32'h3);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (ext_req && ext_we) found = 1'b1;
    end
    chk("mrst_reach_ext_wr", 64'(found), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("mrst_req_drop", 64'({ext_req, ext_we, dma_sel}), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    forbid = 1'b1;
    cfg_read(2'd3, rd);
    chk("mrst_ctrl_rd", 64'(rd), 64'(0));
    cfg_read(2'd0, rd);
    chk("mrst_ext_rd", 64'(rd), 64'(0));
    repeat (5) @(posedge clk);
    #1 forbid = 1'b0;
    chk("final_queues", 64'(exp_ext.size() + exp_ram.size() + exp_done), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
